logic_unit_arbiter: RTL and testbench
=====================================

# logic_unit_arbiter

Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR) between NREQ requesters. A round-robin arbiter selects one pending request, captures its operands and opcode, and computes the result. The result is held in a registered output slot with a valid/ready handshake. The block sits between several datapath clients and the single shared gate resource, so that no client needs its own copy.

## Interface
- WIDTH, 4: operand/result width in bits.
- NREQ, 4: number of requesters, 2..8. IDW = $clog2(NREQ).
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  NREQ  request bit per requester. Held high with operands stable until granted.
- op_i  in  2*NREQ  opcode per requester; slice i is [2i+1:2i].
- a_i  in  WIDTH*NREQ  operand A per requester; slice i is [WIDTH*i +: WIDTH].
- b_i  in  WIDTH*NREQ  operand B per requester, same slicing as a_i.
- gnt  out  NREQ  one-hot grant (combinational). Requester i is accepted on any cycle where req[i] & gnt[i].
- res_valid  out  1  result slot full.
- res_ready  in  1  consumer accepts the result on any cycle where res_valid & res_ready.
- res_data  out  WIDTH  result.
- res_id  out  IDW  index of the requester that owns res_data.
- res_err  out  1  opcode was illegal (11).

## Operation
- Opcodes:
  - 00: a&b
  - 01: a|b
  - 10: a^b
  - 11: illegal. res_data = 0 and res_err = 1.
- Two-state FSM:
  - EMPTY to FULL: on an accept.
  - FULL to EMPTY: on a consume with no accept in the same cycle.
  - FULL to FULL: on a consume plus an accept in the same cycle.
- Grant window: `open = (state==EMPTY) | (state==FULL & res_ready)`. When open is 0, gnt = 0.
- Arbitration is round-robin over req when open:
  - Search starts at index `ptr` and wraps modulo NREQ.
  - The first set req bit wins. At most one gnt bit is set.
  - On an accept of index k, `ptr <= (k+1) mod NREQ`. With no accept, ptr holds.
- On accept, the block registers res_data (the computed function), res_err, res_id = k, and res_valid = 1.
- Result registers change only on an accept. They hold while res_valid=1 and res_ready=0.
- A consume without an accept clears res_valid. res_data, res_id and res_err keep their last values.
- Fairness: with all req held high, each requester is granted exactly once in every NREQ consecutive grants.
- Requests not granted are not queued. The requester keeps req high.
- Reset values:
  - res_valid = 0, res_data = 0, res_id = 0, res_err = 0
  - ptr = 0, state = EMPTY
  - gnt = 0 while rst = 1
- Reset mid-operation discards any held result. Reset has priority over accept and consume in the same cycle.

## Timing
- Latency: an accept in cycle N gives res_valid = 1 with the result in cycle N+1.
- Throughput: one operation per cycle when res_ready stays high (accept and consume in the same cycle).
- Backpressure: with res_valid=1 and res_ready=0, gnt = 0 and all outputs are stable.
- Path from req/res_ready to gnt is combinational. No path runs from a_i/b_i/op_i to any output except through the result register.
- gnt is valid only when rst = 0.
- The first cycle after reset deasserts is EMPTY. A pending req is granted in that cycle.

## Test plan
- Reset, then req=0001, op 00, a=1100, b=1010 → gnt=0001 in the same cycle; next cycle res_valid=1, res_data=1000, res_id=0, res_err=0.
- Single requester 2 issues OR then XOR back-to-back with a=0110, b=0011 and res_ready=1 → res_data=0111, then 0101 on consecutive cycles. Throughput is 1/cycle.
- req=1111 held, res_ready=1 for 8 cycles → grant order 0,1,2,3,0,1,2,3. res_id follows the same sequence.
- Result valid and res_ready=0 for 3 cycles with req=0110 → gnt=0000 and res_data/res_id stable. On res_ready=1, gnt=0010 in the same cycle and res_id=1 on the next cycle.
- op=11 from requester 3 → res_data=0000, res_err=1, res_id=3. A following AND clears res_err.
- Assert rst while res_valid=1 and req=1111 → next cycle res_valid=0 and ptr=0. After release, requester 0 is granted first.

Source files
------------

// File: rtl/logic_unit_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter_if
// Brief    : Request/result bundle between clients and the shared logic unit.
// Revision : 1.0 - initial release
// ============================================================================
interface logic_unit_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req;
    logic [2*NREQ-1:0]     op_i;
    logic [WIDTH*NREQ-1:0] a_i;
    logic [WIDTH*NREQ-1:0] b_i;
    logic [NREQ-1:0]       gnt;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_data;
    logic [IDW-1:0]        res_id;
    logic                  res_err;

    modport master (
        output req, op_i, a_i, b_i, res_ready,
        input  gnt, res_valid, res_data, res_id, res_err
    );

    modport slave (
        input  req, op_i, a_i, b_i, res_ready,
        output gnt, res_valid, res_data, res_id, res_err
    );
endinterface
`default_nettype wire

// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter
// Brief    : Round-robin shared AND/OR/XOR unit with a one-entry result slot.
// Revision : 1.0 - initial release
// ============================================================================
module logic_unit_arbiter #(
    parameter int WIDTH = 4,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    logic_unit_arbiter_if.slave   bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [WIDTH-1:0] r_data;
    logic             r_err;

    logic             w_open;
    logic             w_accept;
    logic [IDW-1:0]   w_idx;
    logic [IDW-1:0]   w_ptr_next;
    logic [NREQ-1:0]  w_gnt;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic [1:0]       w_op;
    logic [WIDTH-1:0] w_data;
    logic             w_err;

    // Rotating priority search; reset masks the grant entirely.
    always_comb begin : p_arb
        logic [IDW-1:0] v_cand;
        v_cand   = '0;
        w_gnt    = '0;
        w_accept = 1'b0;
        w_idx    = '0;
        w_open   = (r_state == EMPTY) || bus.res_ready;
        if (!rst && w_open) begin
            for (int o = 0; o < NREQ; o++) begin
                v_cand = IDW'((int'(r_ptr) + o) % NREQ);
                if (!w_accept && bus.req[v_cand]) begin
                    w_accept      = 1'b1;
                    w_idx         = v_cand;
                    w_gnt[v_cand] = 1'b1;
                end
            end
        end
    end

    always_comb begin : p_operands
        w_a  = '0;
        w_b  = '0;
        w_op = 2'b00;
        for (int i = 0; i < NREQ; i++) begin
            if (w_idx == IDW'(i)) begin
                w_a  = bus.a_i[WIDTH*i +: WIDTH];
                w_b  = bus.b_i[WIDTH*i +: WIDTH];
                w_op = bus.op_i[2*i +: 2];
            end
        end
    end

    always_comb begin : p_alu
        w_data = '0;
        w_err  = 1'b0;
        case (w_op)
            2'b00:   w_data = w_a & w_b;
            2'b01:   w_data = w_a | w_b;
            2'b10:   w_data = w_a ^ w_b;
            default: w_err  = 1'b1;
        endcase
    end

    assign w_ptr_next = (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;

    always_comb begin : p_fsm_next
        w_state_next = r_state;
        case (r_state)
            EMPTY:   if (w_accept) w_state_next = FULL;
            FULL:    if (w_accept) w_state_next = FULL;
                     else if (bus.res_ready) w_state_next = EMPTY;
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin : p_regs
        if (rst) begin
            r_state <= EMPTY;
            r_ptr   <= '0;
            r_id    <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_accept) begin
                r_ptr  <= w_ptr_next;
                r_id   <= w_idx;
                r_data <= w_data;
                r_err  <= w_err;
            end
        end
    end

    assign bus.gnt       = w_gnt;
    assign bus.res_valid = (r_state == FULL);
    assign bus.res_data  = r_data;
    assign bus.res_id    = r_id;
    assign bus.res_err   = r_err;
endmodule
`default_nettype wire

// File: tb/tb_logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_logic_unit_arbiter
// Brief    : Directed bench with a behavioural reference model for the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_logic_unit_arbiter;
    localparam int WIDTH = 4;
    localparam int NREQ  = 4;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    logic_unit_arbiter_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

    logic_unit_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference model: slot contents plus rotating start index.
    bit       m_valid;
    int       m_data;
    int       m_id;
    int       m_err;
    int       m_ptr;
    bit       p_rst;
    bit       p_acc;
    bit       p_cons;
    int       p_k;
    int       p_data;
    int       p_err;

    function automatic int model_gnt_idx();
        if (rst) return -1;
        if (m_valid && !bus.res_ready) return -1;
        for (int o = 0; o < NREQ; o++) begin
            int k;
            k = (m_ptr + o) % NREQ;
            if (((bus.req >> k) & 4'd1) != 4'd0) return k;
        end
        return -1;
    endfunction

    initial begin : p_compare
        int k;
        int opc;
        int a;
        int b;
        m_valid = 0; m_data = 0; m_id = 0; m_err = 0; m_ptr = 0;
        p_rst = 1; p_acc = 0; p_cons = 0; p_k = 0; p_data = 0; p_err = 0;
        forever begin
            @(posedge clk);
            if (rst) begin
                m_valid = 0; m_data = 0; m_id = 0; m_err = 0; m_ptr = 0;
            end else if (p_acc) begin
                m_valid = 1; m_data = p_data; m_err = p_err; m_id = p_k;
                m_ptr = (p_k + 1) % NREQ;
            end else if (p_cons) begin
                m_valid = 0;
            end
            @(negedge clk);
            k = model_gnt_idx();
            check("gnt", int'(bus.gnt), (k < 0) ? 0 : (1 << k));
            check("res_valid", int'(bus.res_valid), int'(m_valid));
            check("res_data", int'(bus.res_data), m_data);
            check("res_id", int'(bus.res_id), m_id);
            check("res_err", int'(bus.res_err), m_err);
            p_acc  = (k >= 0);
            p_cons = m_valid && bus.res_ready;
            p_k    = k;
            p_data = 0;
            p_err  = 0;
            if (k >= 0) begin
                opc = int'((bus.op_i >> (2*k)) & 8'h3);
                a   = int'((bus.a_i >> (WIDTH*k)) & 16'hF);
                b   = int'((bus.b_i >> (WIDTH*k)) & 16'hF);
                if (opc == 0)      p_data = a & b;
                else if (opc == 1) p_data = a | b;
                else if (opc == 2) p_data = a ^ b;
                else               p_err  = 1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [1:0] op,
                          input logic [3:0] a, input logic [3:0] b);
        bus.op_i[2*i +: 2]         = op;
        bus.a_i[WIDTH*i +: WIDTH]  = a;
        bus.b_i[WIDTH*i +: WIDTH]  = b;
    endtask

    initial begin : p_stim
        total = 0;
        bad   = 0;
        rst = 1'b1;
        bus.req = '0; bus.op_i = '0; bus.a_i = '0; bus.b_i = '0;
        bus.res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // First request right after reset release.
        rst = 1'b0;
        bus.req = 4'b0001;
        set_op(0, 2'b00, 4'b1100, 4'b1010);
        @(negedge clk);
        check("t1_gnt", int'(bus.gnt), 4'b0001);
        tick();
        bus.req = '0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("t1_valid", int'(bus.res_valid), 1);
        check("t1_data", int'(bus.res_data), 4'b1000);
        check("t1_id", int'(bus.res_id), 0);
        check("t1_err", int'(bus.res_err), 0);

        // Back-to-back OR then XOR from requester 2.
        tick();
        bus.req = 4'b0100;
        set_op(2, 2'b01, 4'b0110, 4'b0011);
        @(negedge clk);
        check("t2_gnt0", int'(bus.gnt), 4'b0100);
        tick();
        set_op(2, 2'b10, 4'b0110, 4'b0011);
        @(negedge clk);
        check("t2_or", int'(bus.res_data), 4'b0111);
        check("t2_gnt1", int'(bus.gnt), 4'b0100);
        tick();
        bus.req = '0;
        @(negedge clk);
        check("t2_xor", int'(bus.res_data), 4'b0101);
        check("t2_valid", int'(bus.res_valid), 1);

        // Fairness under full load after a fresh reset.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.req = 4'b1111;
        for (int i = 0; i < NREQ; i++) set_op(i, 2'b00, 4'(i + 8), 4'hF);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("rr_gnt", int'(bus.gnt), 1 << (c % 4));
            if (c > 0) check("rr_id", int'(bus.res_id), (c - 1) % 4);
            tick();
        end

        // Backpressure holds the slot and blocks grants.
        bus.res_ready = 1'b0;
        bus.req = 4'b0110;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_gnt", int'(bus.gnt), 0);
            check("bp_id", int'(bus.res_id), 3);
            check("bp_data", int'(bus.res_data), 4'hB);
            tick();
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check("bp_release_gnt", int'(bus.gnt), 4'b0010);
        tick();

        // Illegal opcode, then a legal AND clears the error flag.
        bus.req = 4'b1000;
        set_op(3, 2'b11, 4'b1111, 4'b1111);
        @(negedge clk);
        check("bp_id_next", int'(bus.res_id), 1);
        check("ill_gnt", int'(bus.gnt), 4'b1000);
        tick();
        set_op(3, 2'b00, 4'b1111, 4'b0101);
        @(negedge clk);
        check("ill_data", int'(bus.res_data), 0);
        check("ill_err", int'(bus.res_err), 1);
        check("ill_id", int'(bus.res_id), 3);
        tick();
        bus.req = '0;
        @(negedge clk);
        check("and_err", int'(bus.res_err), 0);
        check("and_data", int'(bus.res_data), 4'b0101);

        // Reset while a result is held discards it and rewinds the pointer.
        tick();
        bus.req = 4'b1111;
        bus.res_ready = 1'b0;
        @(negedge clk);
        check("rst_pre_gnt", int'(bus.gnt), 4'b0001);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("rst_gnt", int'(bus.gnt), 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", int'(bus.res_valid), 0);
        check("rst_first_gnt", int'(bus.gnt), 4'b0001);
        tick();
        bus.req = '0;
        @(negedge clk);
        check("rst_first_id", int'(bus.res_id), 0);
        check("rst_first_valid", int'(bus.res_valid), 1);

        tick();
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
